decode_stage: RTL

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// RV32I decode pipeline stage: a one-deep registered skid between fetch and
// execute that turns an instruction word into ALU/memory/control fields.
module decode_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [31:0]      out_imm,
  output logic [2:0]       out_funct3,
  output logic             out_funct7_5b,
  output logic [1:0]       out_a_sel,
  output logic [1:0]       out_b_sel,
  output logic             out_reg_write,
  output logic             out_mem_read,
  output logic             out_mem_write,
  output logic             out_branch,
  output logic             out_jump,
  output logic             out_br_zero,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_count
);

  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        accept;

  logic [31:0] d_imm;
  logic [2:0]  d_funct3;
  logic        d_funct7_5b, d_reg_write, d_mem_read, d_mem_write;
  logic        d_branch, d_jump, d_br_zero, d_illegal;
  logic [1:0]  d_a_sel, d_b_sel;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b  = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u  = {in_instr[31:12], 12'b0};
  assign imm_j  = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

  assign in_ready = (!out_valid || out_ready) && !flush && !reset;
  assign accept   = in_valid && in_ready;

  always_comb begin
    d_imm       = '0;
    d_funct3    = 3'b000;
    d_funct7_5b = 1'b0;
    d_a_sel     = 2'b00;
    d_b_sel     = 2'b00;
    d_reg_write = 1'b0;
    d_mem_read  = 1'b0;
    d_mem_write = 1'b0;
    d_branch    = 1'b0;
    d_jump      = 1'b0;
    d_br_zero   = 1'b0;
    d_illegal   = 1'b0;
    unique case (opcode)
      OP_REG: begin
        d_funct3    = funct3;
        d_funct7_5b = in_instr[30];
        d_reg_write = 1'b1;
        d_illegal   = !((funct7 == 7'b0000000) ||
                        (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)));
      end
      OP_IMM: begin
        // Only shift-right uses bit 30 as a variant; ADDI's immediate sign must not select SUB.
        d_imm       = imm_i;
        d_funct3    = funct3;
        d_funct7_5b = (funct3 == 3'b101) ? in_instr[30] : 1'b0;
        d_b_sel     = 2'b01;
        d_reg_write = 1'b1;
        if (funct3 == 3'b001)
          d_illegal = (funct7 != 7'b0000000);
        else if (funct3 == 3'b101)
          d_illegal = !(funct7 == 7'b0000000 || funct7 == 7'b0100000);
      end
      LUI: begin
        d_imm       = imm_u;
        d_a_sel     = 2'b10;
        d_b_sel     = 2'b01;
        d_reg_write = 1'b1;
      end
      AUIPC: begin
        d_imm       = imm_u;
        d_a_sel     = 2'b01;
        d_b_sel     = 2'b01;
        d_reg_write = 1'b1;
      end
      JAL, JALR: begin
        d_imm       = (opcode == JAL) ? imm_j : imm_i;
        d_a_sel     = 2'b01;
        d_b_sel     = 2'b10;
        d_jump      = 1'b1;
        d_reg_write = 1'b1;
        d_illegal   = (opcode == JALR) && (funct3 != 3'b000);
      end
      LOAD: begin
        d_imm       = imm_i;
        d_b_sel     = 2'b01;
        d_mem_read  = 1'b1;
        d_reg_write = 1'b1;
        d_illegal   = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      STORE: begin
        d_imm       = imm_s;
        d_b_sel     = 2'b01;
        d_mem_write = 1'b1;
        d_illegal   = (funct3 > 3'b010);
      end
      BRANCH: begin
        // EQ/NE reuse SUB; the ALU's nonzero flag is inverted for EQ via br_zero.
        d_imm    = imm_b;
        d_branch = 1'b1;
        case (funct3)
          3'b000: begin d_funct3 = 3'b000; d_funct7_5b = 1'b1; d_br_zero = 1'b1; end
          3'b001: begin d_funct3 = 3'b000; d_funct7_5b = 1'b1; end
          3'b100: begin d_funct3 = 3'b010; end
          3'b101: begin d_funct3 = 3'b010; d_funct7_5b = 1'b1; end
          3'b110: begin d_funct3 = 3'b011; end
          3'b111: begin d_funct3 = 3'b011; d_funct7_5b = 1'b1; end
          default: d_illegal = 1'b1;
        endcase
      end
      default: d_illegal = 1'b1;
    endcase
    if (d_illegal) begin
      d_reg_write = 1'b0;
      d_mem_read  = 1'b0;
      d_mem_write = 1'b0;
      d_branch    = 1'b0;
      d_jump      = 1'b0;
    end
  end

  // Fields load only on accept, so a stalled bundle holds by construction.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid     <= 1'b0;
      out_pc        <= '0;
      out_rs1       <= '0;
      out_rs2       <= '0;
      out_rd        <= '0;
      out_imm       <= '0;
      out_funct3    <= '0;
      out_funct7_5b <= 1'b0;
      out_a_sel     <= '0;
      out_b_sel     <= '0;
      out_reg_write <= 1'b0;
      out_mem_read  <= 1'b0;
      out_mem_write <= 1'b0;
      out_branch    <= 1'b0;
      out_jump      <= 1'b0;
      out_br_zero   <= 1'b0;
      out_illegal   <= 1'b0;
      illegal_count <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      out_pc        <= in_pc;
      out_rs1       <= in_instr[19:15];
      out_rs2       <= in_instr[24:20];
      out_rd        <= in_instr[11:7];
      out_imm       <= d_imm;
      out_funct3    <= d_funct3;
      out_funct7_5b <= d_funct7_5b;
      out_a_sel     <= d_a_sel;
      out_b_sel     <= d_b_sel;
      out_reg_write <= d_reg_write;
      out_mem_read  <= d_mem_read;
      out_mem_write <= d_mem_write;
      out_branch    <= d_branch;
      out_jump      <= d_jump;
      out_br_zero   <= d_br_zero;
      out_illegal   <= d_illegal;
      if (d_illegal && (illegal_count != '1))
        illegal_count <= illegal_count + CNT_W'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
